// File: rtl/reorder_buffer_if.sv
// Issue/CDB/query/commit/redirect bundle between the Tomasulo core and the reorder buffer.
// The ROB takes the slave modport; the issue stage, CDB and register file side take master.
interface reorder_buffer_if #(
    parameter int ROB_LOG = 4
);
    logic               issue_valid;
    logic [4:0]         issue_rd;
    logic               issue_is_branch;
    logic [ROB_LOG-1:0] issue_RobId;
    logic               rob_full;

    logic               cdb_valid;
    logic [ROB_LOG-1:0] cdb_RobId;
    logic [31:0]        cdb_value;
    logic               cdb_mispredict;
    logic [31:0]        cdb_target;

    logic [ROB_LOG-1:0] query_j_id;
    logic               query_j_ready;
    logic [31:0]        query_j_value;
    logic [ROB_LOG-1:0] query_k_id;
    logic               query_k_ready;
    logic [31:0]        query_k_value;

    logic               commit_valid;
    logic [4:0]         commit_dest;
    logic [31:0]        commit_value;
    logic [ROB_LOG-1:0] commit_RobId;

    logic               jump_flag;
    logic [31:0]        jump_pc;

    modport slave (
        input  issue_valid, issue_rd, issue_is_branch,
        output issue_RobId, rob_full,
        input  cdb_valid, cdb_RobId, cdb_value, cdb_mispredict, cdb_target,
        input  query_j_id, query_k_id,
        output query_j_ready, query_j_value, query_k_ready, query_k_value,
        output commit_valid, commit_dest, commit_value, commit_RobId,
        output jump_flag, jump_pc
    );

    modport master (
        output issue_valid, issue_rd, issue_is_branch,
        input  issue_RobId, rob_full,
        output cdb_valid, cdb_RobId, cdb_value, cdb_mispredict, cdb_target,
        output query_j_id, query_k_id,
        input  query_j_ready, query_j_value, query_k_ready, query_k_value,
        input  commit_valid, commit_dest, commit_value, commit_RobId,
        input  jump_flag, jump_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate at issue, complete from the CDB, retire one per cycle.
// Define ROB_CDB_FWD_EN to forward a same-cycle CDB broadcast onto the operand query ports.
module reorder_buffer #(
    parameter int ROB_LOG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    reorder_buffer_if.slave   rob
);
    localparam int DEPTH = 1 << ROB_LOG;

    logic [ROB_LOG-1:0] head;
    logic [ROB_LOG-1:0] tail;
    logic [ROB_LOG:0]   count;
    logic [DEPTH-1:0]   busy;
    logic [DEPTH-1:0]   done;

    logic [4:0]         dest   [DEPTH];
    logic [31:0]        value  [DEPTH];
    logic [31:0]        target [DEPTH];
    logic [DEPTH-1:0]   is_br;
    logic [DEPTH-1:0]   mispred;

    logic               vld_p1;
    logic [4:0]         commit_dest_p1;
    logic [31:0]        commit_value_p1;
    logic [ROB_LOG-1:0] commit_id_p1;
    logic               jump_flag_p1;
    logic [31:0]        jump_pc_p1;

    logic full;
    logic alloc;
    logic wb;
    logic retire;
    logic flush;

    // count never exceeds DEPTH, so its MSB alone marks a full buffer
    assign full   = count[ROB_LOG];
    assign alloc  = rob.issue_valid && !full && !jump_flag_p1;
    assign wb     = rob.cdb_valid && busy[rob.cdb_RobId];
    assign retire = busy[head] && done[head];
    assign flush  = retire && is_br[head] && mispred[head];

    // Stage p0: pointer / occupancy control and the registered commit + redirect outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            busy            <= '0;
            done            <= '0;
            vld_p1          <= 1'b0;
            commit_dest_p1  <= '0;
            commit_value_p1 <= '0;
            commit_id_p1    <= '0;
            jump_flag_p1    <= 1'b0;
            jump_pc_p1      <= '0;
        end else if (rdy) begin
            vld_p1       <= retire;
            jump_flag_p1 <= flush;
            if (retire) begin
                commit_dest_p1  <= dest[head];
                commit_value_p1 <= value[head];
                commit_id_p1    <= head;
            end
            if (flush) begin
                jump_pc_p1 <= target[head];
                head       <= '0;
                tail       <= '0;
                count      <= '0;
                busy       <= '0;
            end else begin
                if (wb) begin
                    done[rob.cdb_RobId] <= 1'b1;
                end
                if (alloc) begin
                    busy[tail] <= 1'b1;
                    done[tail] <= 1'b0;
                    tail       <= tail + 1'b1;
                end
                if (retire) begin
                    busy[head] <= 1'b0;
                    head       <= head + 1'b1;
                end
                case ({alloc, retire})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Entry payload carries no reset; busy/done decide whether it is meaningful
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (wb) begin
                value[rob.cdb_RobId]   <= rob.cdb_value;
                target[rob.cdb_RobId]  <= rob.cdb_target;
                mispred[rob.cdb_RobId] <= rob.cdb_mispredict;
            end
            if (alloc) begin
                dest[tail]    <= rob.issue_rd;
                is_br[tail]   <= rob.issue_is_branch;
                mispred[tail] <= 1'b0;
            end
        end
    end

    // Operand lookups for the reservation stations
    always_comb begin
        rob.query_j_ready = busy[rob.query_j_id] && done[rob.query_j_id];
        rob.query_j_value = value[rob.query_j_id];
        rob.query_k_ready = busy[rob.query_k_id] && done[rob.query_k_id];
        rob.query_k_value = value[rob.query_k_id];
`ifdef ROB_CDB_FWD_EN
        if (rob.cdb_valid && (rob.cdb_RobId == rob.query_j_id)) begin
            rob.query_j_ready = 1'b1;
            rob.query_j_value = rob.cdb_value;
        end
        if (rob.cdb_valid && (rob.cdb_RobId == rob.query_k_id)) begin
            rob.query_k_ready = 1'b1;
            rob.query_k_value = rob.cdb_value;
        end
`else
`endif
    end

    assign rob.issue_RobId  = tail;
    assign rob.rob_full     = full;
    assign rob.commit_valid = vld_p1;
    assign rob.commit_dest  = commit_dest_p1;
    assign rob.commit_value = commit_value_p1;
    assign rob.commit_RobId = commit_id_p1;
    assign rob.jump_flag    = jump_flag_p1;
    assign rob.jump_pc      = jump_pc_p1;

endmodule
